// File: rtl/udp_app_rx_pkg.sv
// rtl/udp_app_rx_pkg.sv - shared types and helpers for the UDP application receive controller
package udp_app_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_META = 2'd1,
    ST_DATA = 2'd2
  } rx_state_e;

  // Bytes carried by the final payload flit: the low bits of the UDP length,
  // where a zero remainder means the flit is completely full.
  function automatic logic [31:0] last_flit_bytes(input logic [31:0] len, input int bytes_w);
    logic [31:0] mask;
    logic [31:0] rem;
    mask = (32'd1 << bytes_w) - 32'd1;
    rem  = len & mask;
    return (rem == 32'd0) ? (32'd1 << bytes_w) : rem;
  endfunction

endpackage

// File: rtl/udp_app_rx_ctrl.sv
// rtl/udp_app_rx_ctrl.sv - receive-side flit sequencer: header/metadata capture strobes,
// payload forwarding or dropping, byte accounting and end-of-message pulses
module udp_app_rx_ctrl
  import udp_app_rx_pkg::*;
#(
  parameter int NOC_DATA_W = 512,
  parameter int MSG_LEN_W  = 22,
  parameter int UDP_LEN_W  = 16,
  parameter int META_FLITS = 1,
  parameter int DROP_CNT_W = 32
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 in_val,
  output logic                                                 in_rdy,
  input  logic [MSG_LEN_W-1:0]                                 total_flits,
  input  logic [UDP_LEN_W-1:0]                                 data_length,
  input  logic                                                 drop_en,
  output logic                                                 store_hdr,
  output logic                                                 store_meta,
  output logic [((META_FLITS > 1) ? $clog2(META_FLITS) : 1)-1:0] meta_idx,
  output logic                                                 out_val,
  input  logic                                                 out_rdy,
  output logic                                                 out_last,
  output logic [$clog2(NOC_DATA_W/8):0]                        out_bytes,
  output logic                                                 reset_flit_vals,
  output logic                                                 stats_do_log,
  output logic                                                 stats_incr,
  output logic                                                 msg_done,
  output logic                                                 err_short,
  output logic [DROP_CNT_W-1:0]                                drop_cnt
);

  localparam int BYTES      = NOC_DATA_W / 8;
  localparam int BYTES_W    = $clog2(BYTES);
  localparam int OB_W       = BYTES_W + 1;
  localparam int META_IDX_W = (META_FLITS > 1) ? $clog2(META_FLITS) : 1;
  localparam bit HAS_META   = (META_FLITS > 0);

  localparam logic [MSG_LEN_W-1:0]  FLIT_ONE  = MSG_LEN_W'(1);
  localparam logic [META_IDX_W-1:0] META_ONE  = META_IDX_W'(1);
  localparam logic [META_IDX_W-1:0] META_LAST = META_IDX_W'((META_FLITS > 0) ? META_FLITS - 1 : 0);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;
  localparam logic [OB_W-1:0]       FULL_FLIT = OB_W'(BYTES);

  rx_state_e               state, state_d;
  logic [MSG_LEN_W-1:0]    flit_cnt, flit_cnt_d;
  logic [META_IDX_W-1:0]   meta_cnt, meta_cnt_d;
  logic                    drop_q, drop_d;
  logic                    log_d, done_d, err_d, drop_inc;
  logic                    is_last;
  logic [OB_W-1:0]         tail_bytes;

  assign is_last    = (flit_cnt + FLIT_ONE) == total_flits;
  assign tail_bytes = OB_W'(last_flit_bytes(32'(data_length), BYTES_W));

  always_comb begin
    state_d         = state;
    flit_cnt_d      = flit_cnt;
    meta_cnt_d      = meta_cnt;
    drop_d          = drop_q;
    log_d           = stats_do_log;
    done_d          = 1'b0;
    err_d           = 1'b0;
    drop_inc        = 1'b0;
    in_rdy          = 1'b0;
    store_hdr       = 1'b0;
    store_meta      = 1'b0;
    meta_idx        = '0;
    out_val         = 1'b0;
    out_last        = 1'b0;
    out_bytes       = '0;
    stats_incr      = 1'b0;
    reset_flit_vals = 1'b0;

    case (state)
      ST_IDLE: begin
        in_rdy          = 1'b1;
        reset_flit_vals = ~in_val;
        if (in_val) begin
          store_hdr  = 1'b1;
          flit_cnt_d = '0;
          meta_cnt_d = '0;
          drop_d     = drop_en;
          log_d      = 1'b1;
          if (total_flits == '0) begin
            // Header-only message: short whenever metadata was expected.
            done_d = 1'b1;
            err_d  = HAS_META;
          end else begin
            state_d = HAS_META ? ST_META : ST_DATA;
          end
        end
      end

      ST_META: begin
        in_rdy   = 1'b1;
        meta_idx = meta_cnt;
        if (in_val) begin
          store_meta = 1'b1;
          flit_cnt_d = flit_cnt + FLIT_ONE;
          meta_cnt_d = meta_cnt + META_ONE;
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = (meta_cnt != META_LAST);
          end else if (meta_cnt == META_LAST) begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (drop_q) begin
          in_rdy = 1'b1;
        end else begin
          in_rdy    = out_rdy;
          out_val   = in_val;
          out_last  = is_last;
          out_bytes = is_last ? tail_bytes : FULL_FLIT;
        end
        if (in_val && in_rdy) begin
          flit_cnt_d = flit_cnt + FLIT_ONE;
          stats_incr = ~drop_q;
          if (is_last) begin
            reset_flit_vals = 1'b1;
            done_d          = 1'b1;
            drop_inc        = drop_q;
            state_d         = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      flit_cnt     <= '0;
      meta_cnt     <= '0;
      drop_q       <= 1'b0;
      stats_do_log <= 1'b0;
      msg_done     <= 1'b0;
      err_short    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_d;
      flit_cnt     <= flit_cnt_d;
      meta_cnt     <= meta_cnt_d;
      drop_q       <= drop_d;
      stats_do_log <= log_d;
      msg_done     <= done_d;
      err_short    <= err_d;
      if (drop_inc && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_udp_app_rx_ctrl.sv
// tb/tb_udp_app_rx_ctrl.sv - self-checking bench for udp_app_rx_ctrl with one
// instance per metadata depth (1, 3 and 0) and a message-level reference model
module tb_udp_app_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_val_v;
  logic [21:0] total_flits;
  logic [15:0] data_length;
  logic        drop_en;
  logic        out_rdy;

  logic        in_rdy_a[3], store_hdr_a[3], store_meta_a[3], out_val_a[3], out_last_a[3];
  logic        rfv_a[3], log_a[3], incr_a[3], done_a[3], err_a[3];
  logic [6:0]  ob_a[3];
  logic [31:0] dc_a[3];
  logic        mi0;
  logic [1:0]  mi1;
  logic        mi2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_drop[3];
  int meta_of[3] = '{1, 3, 0};

  always #5 clk = ~clk;

  udp_app_rx_ctrl #(.META_FLITS(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val_v[0]), .in_rdy(in_rdy_a[0]),
    .total_flits(total_flits), .data_length(data_length), .drop_en(drop_en),
    .store_hdr(store_hdr_a[0]), .store_meta(store_meta_a[0]), .meta_idx(mi0),
    .out_val(out_val_a[0]), .out_rdy(out_rdy), .out_last(out_last_a[0]), .out_bytes(ob_a[0]),
    .reset_flit_vals(rfv_a[0]), .stats_do_log(log_a[0]), .stats_incr(incr_a[0]),
    .msg_done(done_a[0]), .err_short(err_a[0]), .drop_cnt(dc_a[0])
  );

  udp_app_rx_ctrl #(.META_FLITS(3)) u_m3 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val_v[1]), .in_rdy(in_rdy_a[1]),
    .total_flits(total_flits), .data_length(data_length), .drop_en(drop_en),
    .store_hdr(store_hdr_a[1]), .store_meta(store_meta_a[1]), .meta_idx(mi1),
    .out_val(out_val_a[1]), .out_rdy(out_rdy), .out_last(out_last_a[1]), .out_bytes(ob_a[1]),
    .reset_flit_vals(rfv_a[1]), .stats_do_log(log_a[1]), .stats_incr(incr_a[1]),
    .msg_done(done_a[1]), .err_short(err_a[1]), .drop_cnt(dc_a[1])
  );

  udp_app_rx_ctrl #(.META_FLITS(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_val(in_val_v[2]), .in_rdy(in_rdy_a[2]),
    .total_flits(total_flits), .data_length(data_length), .drop_en(drop_en),
    .store_hdr(store_hdr_a[2]), .store_meta(store_meta_a[2]), .meta_idx(mi2),
    .out_val(out_val_a[2]), .out_rdy(out_rdy), .out_last(out_last_a[2]), .out_bytes(ob_a[2]),
    .reset_flit_vals(rfv_a[2]), .stats_do_log(log_a[2]), .stats_incr(incr_a[2]),
    .msg_done(done_a[2]), .err_short(err_a[2]), .drop_cnt(dc_a[2])
  );

  // {in_rdy, store_hdr, store_meta, meta_idx[1:0], out_val, out_last, out_bytes[6:0], stats_incr, reset_flit_vals}
  function automatic logic [15:0] pk(bit rdy, bit hdr, bit meta, logic [1:0] idx, bit ov,
                                     bit lst, logic [6:0] by, bit inc, bit rfv);
    return {rdy, hdr, meta, idx, ov, lst, by, inc, rfv};
  endfunction

  function automatic logic [15:0] obs(int s);
    logic [1:0] mi;
    mi = (s == 0) ? {1'b0, mi0} : (s == 1) ? mi1 : {1'b0, mi2};
    return {in_rdy_a[s], store_hdr_a[s], store_meta_a[s], mi, out_val_a[s], out_last_a[s],
            ob_a[s], incr_a[s], rfv_a[s]};
  endfunction

  function automatic logic [34:0] reg_obs(int s);
    return {done_a[s], err_a[s], log_a[s], dc_a[s]};
  endfunction

  task automatic idle_check(input string name, input int s);
    @(negedge clk);
    in_val_v = 3'b000;
    #1;
    n_cmp++;
    if (obs(s) !== pk(1, 0, 0, 2'd0, 0, 0, 7'd0, 0, 1)) begin
      n_bad++;
      $display("FAIL %s idle outputs got=%h exp=%h", name, obs(s), pk(1, 0, 0, 2'd0, 0, 0, 7'd0, 0, 1));
    end
  endtask

  // Drives one complete message into instance s and checks every cycle against
  // the message-level model: header, min(total,M) metadata flits, then payload.
  task automatic run_msg(input string name, input int s, input int total, input int len,
                         input bit drop, input int rdy_mode, output int incr_seen);
    int m, p, nmeta, k, cyc, pi;
    bit acc, lastp, er;
    logic [15:0] e;
    logic [6:0] by;
    m = meta_of[s];
    p = (total > m) ? total - m : 0;
    nmeta = (total < m) ? total : m;
    k = 0;
    cyc = 0;
    incr_seen = 0;
    total_flits = 22'(total);
    data_length = 16'(len);
    drop_en = drop;
    while (k <= total && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_val_v = 3'b000;
      in_val_v[s] = 1'b1;
      out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      if (k == 0) begin
        e = pk(1, 1, 0, 2'd0, 0, 0, 7'd0, 0, 0);
        acc = 1;
      end else if (k <= nmeta) begin
        e = pk(1, 0, 1, 2'(k - 1), 0, 0, 7'd0, 0, 0);
        acc = 1;
      end else begin
        pi = k - 1 - m;
        lastp = (pi == p - 1);
        by = lastp ? ((len % 64 == 0) ? 7'd64 : 7'(len % 64)) : 7'd64;
        if (drop) begin
          e = pk(1, 0, 0, 2'd0, 0, 0, 7'd0, 0, lastp);
          acc = 1;
        end else begin
          e = pk(out_rdy, 0, 0, 2'd0, 1, lastp, by, out_rdy, lastp && out_rdy);
          acc = out_rdy;
        end
      end
      #1;
      n_cmp++;
      if (obs(s) !== e) begin
        n_bad++;
        $display("FAIL %s flit=%0d got=%h exp=%h", name, k, obs(s), e);
      end
      if (incr_a[s]) incr_seen++;
      if (acc) k++;
    end
    if (k <= total) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout flit=%0d of %0d", name, k, total);
    end
    @(posedge clk);
    #1;
    in_val_v = 3'b000;
    if (drop && p > 0) exp_drop[s]++;
    er = (m > 0) && (total < m);
    n_cmp++;
    if (reg_obs(s) !== {1'b1, er, 1'b1, 32'(exp_drop[s])}) begin
      n_bad++;
      $display("FAIL %s done/err/log/drop got=%h exp=%h", name, reg_obs(s), {1'b1, er, 1'b1, 32'(exp_drop[s])});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (reg_obs(s) !== {1'b0, 1'b0, 1'b1, 32'(exp_drop[s])}) begin
      n_bad++;
      $display("FAIL %s pulse clear got=%h exp=%h", name, reg_obs(s), {1'b0, 1'b0, 1'b1, 32'(exp_drop[s])});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_val_v = 3'b000;
    out_rdy = 1'b0;
    total_flits = '0;
    data_length = '0;
    drop_en = 1'b0;
    for (int s = 0; s < 3; s++) exp_drop[s] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      idle_check("reset_idle", s);
      n_cmp++;
      if (reg_obs(s) !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_regs inst=%0d got=%h exp=0", s, reg_obs(s));
      end
    end
  endtask

  task automatic test_basic();
    int inc;
    run_msg("basic", 0, 3, 100, 0, 0, inc);
    idle_check("basic_after", 0);
  endtask

  task automatic test_backpressure();
    int inc;
    run_msg("backpressure", 0, 3, 128, 0, 1, inc);
    n_cmp++;
    if (inc !== 2) begin
      n_bad++;
      $display("FAIL backpressure stats_incr count got=%0d exp=2", inc);
    end
    idle_check("backpressure_after", 0);
  endtask

  task automatic test_short_meta();
    int inc;
    run_msg("short_meta", 1, 2, 50, 0, 0, inc);
    idle_check("short_meta_after", 1);
  endtask

  task automatic test_drop();
    int inc;
    run_msg("drop", 0, 5, 200, 1, 2, inc);
    n_cmp++;
    if (inc !== 0) begin
      n_bad++;
      $display("FAIL drop stats_incr count got=%0d exp=0", inc);
    end
    idle_check("drop_after", 0);
  endtask

  task automatic test_header_only();
    int inc;
    run_msg("header_only", 2, 0, 0, 0, 0, inc);
    idle_check("header_only_after", 2);
  endtask

  task automatic test_reset_mid();
    int inc;
    @(negedge clk);
    total_flits = 22'd6;
    data_length = 16'd300;
    drop_en = 1'b0;
    out_rdy = 1'b1;
    in_val_v = 3'b001;
    repeat (4) @(negedge clk);
    in_val_v = 3'b000;
    #2;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) exp_drop[s] = 0;
    #1;
    n_cmp++;
    if (obs(0) !== pk(1, 0, 0, 2'd0, 0, 0, 7'd0, 0, 1)) begin
      n_bad++;
      $display("FAIL reset_mid outputs got=%h exp=%h", obs(0), pk(1, 0, 0, 2'd0, 0, 0, 7'd0, 0, 1));
    end
    n_cmp++;
    if (reg_obs(0) !== 35'd0) begin
      n_bad++;
      $display("FAIL reset_mid regs got=%h exp=0", reg_obs(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_msg("after_reset", 0, 4, 129, 0, 0, inc);
    idle_check("after_reset_idle", 0);
  endtask

  task automatic test_random();
    int inc, s;
    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 2));
      run_msg("random", s, int'($urandom_range(0, 6)), int'($urandom_range(0, 65535)),
              ($urandom_range(0, 3) == 0), 2, inc);
      idle_check("random_idle", s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_meta();
    test_drop();
    test_header_only();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
